// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the ALU arbiter slice: default datapath width, ALU opcodes and
// arbiter state codes.
`timescale 1ns/1ps
package alu_arbiter_pkg;

  localparam int unsigned WORD_SIZE_DEF = 16;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLT = 3'd5;
  localparam logic [2:0] ALU_MUL = 3'd6;
  localparam logic [2:0] ALU_SHL = 3'd7;

  localparam logic [1:0] ARB_IDLE = 2'b00;
  localparam logic [1:0] ARB_EXEC = 2'b01;
  localparam logic [1:0] ARB_RESP = 2'b10;

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin picker. It grants the first request found when scanning
// upward from ptr, wrapping from NUM_REQ-1 back to 0.
`timescale 1ns/1ps
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic                 found;
  int unsigned          pos;

  // Rotating the doubled vector puts requester ptr at bit 0, so a plain
  // lowest-bit-first scan gives the round-robin order.
  always_comb begin
    req_dbl    = {req, req};
    req_rot    = NUM_REQ'(req_dbl >> ptr);
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = |req;
    found      = 1'b0;
    pos        = 0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!found && req_rot[j]) begin
        found = 1'b1;
        pos   = j;
      end
    end
    pos = pos + 32'(ptr);
    if (pos >= NUM_REQ) pos = pos - NUM_REQ;
    if (any) begin
      gnt_idx    = IDX_W'(pos);
      gnt_onehot = NUM_REQ'(1) << pos;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares a single registered ALU among NUM_REQ requesters. It arbitrates round-robin,
// issues one operation at a time and routes the ALU result back to the granted requester.
`timescale 1ns/1ps
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned WORD_SIZE = alu_arbiter_pkg::WORD_SIZE_DEF,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned IDX_W     = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [3*NUM_REQ-1:0]         req_op,
  input  logic [WORD_SIZE*NUM_REQ-1:0] req_in1,
  input  logic [WORD_SIZE*NUM_REQ-1:0] req_in2,
  output logic [NUM_REQ-1:0]           resp_valid,
  input  logic [NUM_REQ-1:0]           resp_ready,
  output logic [WORD_SIZE-1:0]         resp_data,
  output logic [2:0]                   alu_op,
  output logic [WORD_SIZE-1:0]         alu_in1,
  output logic [WORD_SIZE-1:0]         alu_in2,
  output logic                         alu_enable,
  input  logic [WORD_SIZE-1:0]         alu_out,
  output logic                         busy
);

  if (NUM_REQ < 2 || NUM_REQ > (1 << IDX_W)) begin : g_bad_num_req
    $error("alu_arbiter: NUM_REQ=%0d illegal for IDX_W=%0d", NUM_REQ, IDX_W);
  end

  logic [1:0]           state_q,  state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     grant_q,  grant_d;
  logic [2:0]           op_q,     op_d;
  logic [WORD_SIZE-1:0] in1_q,    in1_d;
  logic [WORD_SIZE-1:0] in2_q,    in2_d;

  logic [NUM_REQ-1:0]   arb_onehot;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;
  logic [NUM_REQ-1:0]   grant_onehot;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req        (req_valid),
    .ptr        (rr_ptr_q),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx),
    .any        (arb_any)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    op_d         = op_q;
    in1_d        = in1_q;
    in2_d        = in2_q;
    grant_onehot = NUM_REQ'(1) << grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (arb_any) begin
          state_d = ARB_EXEC;
          grant_d = arb_idx;
          op_d    = 3'(req_op >> (3 * arb_idx));
          in1_d   = WORD_SIZE'(req_in1 >> (WORD_SIZE * arb_idx));
          in2_d   = WORD_SIZE'(req_in2 >> (WORD_SIZE * arb_idx));
        end
      end
      ARB_EXEC: state_d = ARB_RESP;
      ARB_RESP: begin
        if (|(resp_ready & grant_onehot)) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      op_q     <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      op_q     <= op_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
    end
  end

  // Suppress acceptance during reset so no request appears taken on a reset edge.
  assign req_ready  = (state_q == ARB_IDLE && !reset) ? arb_onehot : '0;
  assign resp_valid = (state_q == ARB_RESP) ? grant_onehot : '0;
  assign resp_data  = alu_out;
  assign alu_op     = op_q;
  assign alu_in1    = in1_q;
  assign alu_in2    = in2_q;
  assign alu_enable = (state_q == ARB_EXEC);
  assign busy       = (state_q != ARB_IDLE);

endmodule
